// File: rtl/fpu_sched_pkg.sv
// rtl/fpu_sched_pkg.sv - shared types and constants for the FPU round-robin scheduler
package fpu_sched_pkg;

    localparam logic        FP_ADD  = 1'b0;
    localparam logic        FP_MULT = 1'b1;
    localparam logic [31:0] FP_NAN  = 32'hFFFF_FFFF;

    // Tag id is sized for the largest supported NREQ (8); narrower tops use the low bits.
    localparam int TAG_IDW = 3;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
    } fpu_req_t;

    typedef struct packed {
        logic               v;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/fpu_rr_scheduler_arbiter.sv
// rtl/fpu_rr_scheduler_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);

    localparam int SW = W + 1;

    logic [SW-1:0] slot;

    // Scan from the farthest offset down so the nearest eligible slot after ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        slot        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            slot = {1'b0, ptr} + SW'(k);
            if (slot >= SW'(N)) begin
                slot = slot - SW'(N);
            end
            if (eligible[slot[W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = slot[W-1:0];
            end
        end
    end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// rtl/fpu_rr_scheduler.sv - shares one fixed-latency FPU among NREQ requesters
module fpu_rr_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int FPU_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_a,
    input  logic [NREQ-1:0][31:0] req_b,
    input  logic [NREQ-1:0]       req_op,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [NREQ-1:0][31:0] rsp_y,
    output logic [31:0]           fpu_a,
    output logic [31:0]           fpu_b,
    output logic                  fpu_sel,
    input  logic [31:0]           fpu_y,
    output logic                  busy,
    output logic [15:0]           nan_cnt
);

    localparam int IDW = $clog2(NREQ);

    tag_t            tag_q [FPU_LAT+1];
    logic [NREQ-1:0] in_flight;
    logic [NREQ-1:0] eligible;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_idx;
    logic            grant_valid;
    logic [IDW-1:0]  cap_id;
    tag_t            tag_in;

    always_comb begin
        in_flight = '0;
        for (int s = 0; s <= FPU_LAT; s++) begin
            if (tag_q[s].v) begin
                in_flight[tag_q[s].id[IDW-1:0]] = 1'b1;
            end
        end
    end

    // A held response blocks re-issue, so the capture slot is always free on return.
    assign eligible = req_valid & ~(in_flight | rsp_valid);
    assign busy     = (|in_flight) | (|rsp_valid);
    assign cap_id   = tag_q[FPU_LAT].id[IDW-1:0];
    assign tag_in   = '{v: grant_valid, id: TAG_IDW'(grant_idx)};

    rr_arbiter #(.N(NREQ)) u_arb (
        .eligible    (eligible),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        req_ready = '0;
        if (grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_a     <= '0;
            fpu_b     <= '0;
            fpu_sel   <= 1'b0;
            rr_ptr    <= '0;
            rsp_valid <= '0;
            rsp_y     <= '0;
            nan_cnt   <= '0;
            for (int s = 0; s <= FPU_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            if (grant_valid) begin
                fpu_a   <= req_a[grant_idx];
                fpu_b   <= req_b[grant_idx];
                fpu_sel <= req_op[grant_idx];
                rr_ptr  <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            tag_q[0] <= tag_in;
            for (int s = 1; s <= FPU_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
            if (tag_q[FPU_LAT].v) begin
                rsp_valid[cap_id] <= 1'b1;
                rsp_y[cap_id]     <= fpu_y;
                if (fpu_y == FP_NAN && nan_cnt != 16'hFFFF) begin
                    nan_cnt <= nan_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// tb/tb_fpu_rr_scheduler.sv - randomized and directed checks against a transaction-level model
module tb_fpu_rr_scheduler;
    import fpu_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid, req_ready, req_op, rsp_valid, rsp_ready;
    logic [NREQ-1:0][31:0] req_a, req_b, rsp_y;
    logic [31:0]           fpu_a, fpu_b, fpu_y, fpu_s1;
    logic                  fpu_sel, busy;
    logic [15:0]           nan_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fpu_rr_scheduler #(.NREQ(NREQ), .FPU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sel(fpu_sel), .fpu_y(fpu_y),
        .busy(busy), .nan_cnt(nan_cnt)
    );

    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (a == FP_NAN || b == FP_NAN) return FP_NAN;
        if (op == FP_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == FP_MULT && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        return op ? (a ^ {b[15:0], b[31:16]}) : (a + b);
    endfunction

    // Two-stage FPU stand-in: result appears LAT edges after its operands.
    always @(posedge clk) begin
        fpu_s1 <= fpu_fn(fpu_a, fpu_b, fpu_sel);
        fpu_y  <= fpu_s1;
    end

    // Reference model: per-requester transaction state with completion timestamps.
    bit          m_inflight [NREQ];
    int          m_cap      [NREQ];
    logic [31:0] m_res      [NREQ];
    bit          m_rv       [NREQ];
    logic [31:0] m_y        [NREQ];
    int          grants     [NREQ];
    int          m_rr, m_nan, edge_n;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREQ; i++) begin
            m_inflight[i] = 0; m_rv[i] = 0; m_y[i] = '0; m_cap[i] = 0;
        end
        m_rr = 0; m_nan = 0;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (req_valid[i] && !m_inflight[i] && !m_rv[i]) return i;
        end
        return -1;
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        int  g;
        bit  any;
        #1;
        g = model_grant();
        any = 0;
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("req_ready[%0d]", i), 32'(req_ready[i]), 32'(g == i));
            chk($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(m_rv[i]));
            chk($sformatf("rsp_y[%0d]", i), rsp_y[i], m_y[i]);
            any |= m_inflight[i] | m_rv[i];
        end
        chk("busy", 32'(busy), 32'(any));
        chk("nan_cnt", 32'(nan_cnt), 32'(m_nan));
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < NREQ; i++) begin
            if (m_inflight[i] && m_cap[i] == edge_n) begin
                m_inflight[i] = 0;
                m_rv[i] = 1;
                m_y[i] = m_res[i];
                if (m_res[i] == FP_NAN && m_nan < 65535) m_nan++;
            end else if (m_rv[i] && rsp_ready[i]) begin
                m_rv[i] = 0;
            end
        end
        if (g >= 0) begin
            m_inflight[g] = 1;
            m_cap[g] = edge_n + LAT + 1;
            m_res[g] = fpu_fn(req_a[g], req_b[g], req_op[g]);
            m_rr = (g + 1) % NREQ;
            grants[g]++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_nan_cnt", 32'(nan_cnt), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 4))
            0: return 32'h3F800000;
            1: return 32'h40000000;
            2: return 32'h40400000;
            3: return FP_NAN;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] held;
        int          g1, n0;
        req_valid = '0; req_op = '0; rsp_ready = '0;
        req_a = '0; req_b = '0;
        fpu_s1 = '0; fpu_y = '0;
        edge_n = 0;
        for (int i = 0; i < NREQ; i++) grants[i] = 0;
        model_clear();

        @(negedge clk);
        chk("reset_fpu_a", fpu_a, 32'd0);
        chk("reset_fpu_b", fpu_b, 32'd0);
        chk("reset_fpu_sel", 32'(fpu_sel), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_nan_cnt", 32'(nan_cnt), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_y", rsp_y[0] | rsp_y[1] | rsp_y[2] | rsp_y[3], 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single add on req0, three-edge latency
        rsp_ready = '1;
        req_valid = 4'b0001; req_a[0] = 32'h3F800000; req_b[0] = 32'h40000000; req_op[0] = FP_ADD;
        step();
        req_valid = '0;
        repeat (4) step();
        chk("t1_rsp_y0", rsp_y[0], 32'h40400000);

        // all requesters multiplying back-to-back
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = 32'h40000000; req_b[i] = 32'h40400000; req_op[i] = FP_MULT;
        end
        req_valid = '1;
        repeat (24) step();
        req_valid = '0;
        repeat (6) step();
        for (int i = 0; i < NREQ; i++) chk($sformatf("t2_rsp_y[%0d]", i), rsp_y[i], 32'h40C00000);

        // req1 stalled on its response, others keep flowing
        g1 = grants[1];
        rsp_ready = 4'b1101;
        req_valid = '1;
        req_a[1] = 32'h11111111; req_b[1] = 32'h22222222; req_op[1] = FP_ADD;
        repeat (20) step();
        chk("t3_req1_grants", 32'(grants[1] - g1), 32'd1);
        held = rsp_y[1];
        chk("t3_rsp_y1", held, 32'h33333333);
        req_valid = '0;
        rsp_ready = '1;
        repeat (6) step();

        // NaN operand on req2
        n0 = m_nan;
        req_valid = 4'b0100; req_a[2] = FP_NAN; req_b[2] = 32'h3F800000; req_op[2] = FP_ADD;
        step();
        req_valid = '0;
        repeat (5) step();
        chk("t4_rsp_y2", rsp_y[2], FP_NAN);
        chk("t4_nan_delta", 32'(m_nan - n0), 32'd1);
        chk("t4_nan_cnt", 32'(nan_cnt), 32'(n0 + 1));

        // reset while req0 and req3 are in flight
        do_reset();
        @(negedge clk);
        req_valid = 4'b1001;
        repeat (2) step();
        req_valid = '0;
        do_reset();
        repeat (5) step();
        req_valid = 4'b1100; req_a[3] = 32'h1; req_a[2] = 32'h2;
        step();
        chk("t5_grants_after_reset_to_2", 32'(m_inflight[2]), 32'd1);
        req_valid = '0;
        repeat (6) step();

        // same-cycle response handshake and new request on req0
        req_valid = 4'b0001; req_a[0] = 32'h3F800000; req_b[0] = 32'h40000000; req_op[0] = FP_ADD;
        repeat (12) step();
        req_valid = '0;
        repeat (6) step();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                rsp_ready[i] = ($urandom_range(0, 9) < 7);
                req_a[i] = rand_opnd();
                req_b[i] = rand_opnd();
                req_op[i] = $urandom_range(0, 1) == 1;
            end
            step();
        end
        req_valid = '0; rsp_ready = '1;
        repeat (8) step();
        chk("final_idle_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
